// File: rtl/top_multiplier.sv
// Self-stimulating 32x32 unsigned multiplier: LFSR and counter operands feed a
// two-stage pipeline (16x16 partial products, then shift-add) producing P.
module top_multiplier (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [63:0] P
);

   localparam logic [31:0] TAP_MASK = 32'h8020_0003;
   localparam logic [31:0] SEED     = 32'h0000_0001;

   // Right-shifting Galois step for x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      logic [31:0] nxt;
      nxt = {1'b0, cur[31:1]};
      if (cur[0]) begin
         nxt = nxt ^ TAP_MASK;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

   logic [31:0] pp_ll_r;
   logic [31:0] pp_lh_r;
   logic [31:0] pp_hl_r;
   logic [31:0] pp_hh_r;
   logic [63:0] sum_s;

   // Operand generators: LFSR on A, free-running up-counter on B.
   always_ff @(posedge clk) begin
      if (!rst) begin
         A <= SEED;
         B <= SEED;
      end else begin
         A <= lfsr_next(A);
         B <= B + 32'd1;
      end
   end

   // Stage 1: register the four 16x16 partial products.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pp_ll_r <= 32'h0;
         pp_lh_r <= 32'h0;
         pp_hl_r <= 32'h0;
         pp_hh_r <= 32'h0;
      end else begin
         pp_ll_r <= {16'h0, A[15:0]}  * {16'h0, B[15:0]};
         pp_lh_r <= {16'h0, A[15:0]}  * {16'h0, B[31:16]};
         pp_hl_r <= {16'h0, A[31:16]} * {16'h0, B[15:0]};
         pp_hh_r <= {16'h0, A[31:16]} * {16'h0, B[31:16]};
      end
   end

   // Shift-add of the partials; cross terms carry weight 2^16.
   always_comb begin
      sum_s = {32'h0, pp_ll_r}
            + {16'h0, pp_lh_r, 16'h0}
            + {16'h0, pp_hl_r, 16'h0}
            + {pp_hh_r, 32'h0};
   end

   // Stage 2: register the full 64-bit product.
   always_ff @(posedge clk) begin
      if (!rst) begin
         P <= 64'h0;
      end else begin
         P <= sum_s;
      end
   end

endmodule

// File: tb/tb_top_multiplier.sv
// Directed and model-based checks for top_multiplier: reset, operand sequence,
// pipeline latency, mid-run reset, 1000-cycle sweep and arithmetic corners.
module tb_top_multiplier;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [63:0] P;

   int checks   = 0;
   int failures = 0;

   logic [31:0] a_tab [4] = '{32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
   logic [31:0] b_tab [4] = '{32'd2, 32'd3, 32'd4, 32'd5};
   logic [63:0] p_tab [4] = '{64'h0, 64'h1, 64'h0000_0001_0040_0006, 64'h0000_0002_4090_0006};

   top_multiplier dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .P   (P)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_seq(input string tag);
      for (int i = 0; i < 4; i++) begin
         step();
         check({tag, "_A"}, {32'h0, A}, {32'h0, a_tab[i]});
         check({tag, "_B"}, {32'h0, B}, {32'h0, b_tab[i]});
         check({tag, "_P"}, P, p_tab[i]);
      end
   endtask

   function automatic logic [31:0] model_lfsr(input logic [31:0] cur);
      logic [31:0] n;
      n = cur >> 1;
      if (cur[0] == 1'b1) n = n ^ 32'h8020_0003;
      return n;
   endfunction

   initial begin
      logic [31:0] a_m;
      logic [31:0] b_m;
      logic [63:0] s1_m;
      logic [63:0] p_m;

      rst = 1'b0;
      @(negedge clk);
      step();
      step();
      check("reset_A", {32'h0, A}, 64'h1);
      check("reset_B", {32'h0, B}, 64'h1);
      check("reset_P", P, 64'h0);

      rst = 1'b1;
      run_seq("seq");

      for (int i = 0; i < 10; i++) step();
      rst = 1'b0;
      step();
      check("midrst_A", {32'h0, A}, 64'h1);
      check("midrst_B", {32'h0, B}, 64'h1);
      check("midrst_P", P, 64'h0);
      rst = 1'b1;
      run_seq("reseq");

      rst = 1'b0;
      step();
      rst = 1'b1;
      a_m  = 32'h1;
      b_m  = 32'h1;
      s1_m = 64'h0;
      p_m  = 64'h0;
      for (int k = 0; k < 1000; k++) begin
         step();
         p_m  = s1_m;
         s1_m = {32'h0, a_m} * {32'h0, b_m};
         a_m  = model_lfsr(a_m);
         b_m  = b_m + 32'd1;
         check("sweep_A", {32'h0, A}, {32'h0, a_m});
         check("sweep_B", {32'h0, B}, {32'h0, b_m});
         check("sweep_P", P, p_m);
      end

      force dut.A = 32'hFFFF_FFFF;
      force dut.B = 32'hFFFF_FFFF;
      #2;
      release dut.A;
      release dut.B;
      step();
      check("wrap_B", {32'h0, B}, 64'h0);
      check("corner_A_next", {32'h0, A}, 64'h0000_0000_FFDF_FFFC);
      step();
      check("corner_P", P, 64'hFFFF_FFFE_0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
